// File: rtl/fsm_6s2i2o_steer.sv
// Steering engine for the 6-state/2-input/2-output Moore FSM: walks a registered
// copy of the FSM to a requested target state and reports the number of steps taken.
//
// Handshakes: a transfer happens on a rising edge where both val and rdy are high;
// val, once raised, holds its payload stable until that edge (req_val/req_target
// from the requester, rsp_val/rsp_steps/rsp_err from this block).
module fsm_6s2i2o_steer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_val,
  output logic       req_rdy,
  input  logic [2:0] req_target,
  output logic       rsp_val,
  input  logic       rsp_rdy,
  output logic [2:0] rsp_steps,
  output logic       rsp_err,
  output logic       step,
  output logic [1:0] in_,
  output logic [2:0] state,
  output logic       out0,
  output logic       out1,
  output logic [1:0] dbg_ctrl
);

  typedef enum logic [2:0] {
    S_A = 3'd0,
    S_B = 3'd1,
    S_C = 3'd2,
    S_D = 3'd3,
    S_E = 3'd4,
    S_F = 3'd5
  } fsm_e;

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_STEP = 2'd1,
    C_RESP = 2'd2
  } ctrl_e;

  fsm_e       r_state;
  fsm_e       w_state_nxt;
  ctrl_e      r_ctrl;
  ctrl_e      w_ctrl_nxt;
  logic [2:0] r_target;
  logic [2:0] w_target_nxt;
  logic [2:0] r_steps;
  logic [2:0] w_steps_nxt;
  logic       r_err;
  logic       w_err_nxt;
  logic [1:0] w_in;
  logic       w_step;
  logic       w_req_rdy;
  logic       w_rsp_val;

  // Transition table of the tracked FSM; the unused encodings fall back to A.
  function automatic fsm_e fsm_next(input fsm_e st, input logic [1:0] in_v);
    fsm_e nx;
    nx = S_A;
    case (st)
      S_A: case (in_v)
             2'b00:   nx = S_A;
             2'b01:   nx = S_B;
             2'b10:   nx = S_A;
             default: nx = S_E;
           endcase
      S_B: case (in_v)
             2'b00:   nx = S_C;
             2'b01:   nx = S_B;
             2'b10:   nx = S_A;
             default: nx = S_E;
           endcase
      S_C: case (in_v)
             2'b00:   nx = S_A;
             2'b01:   nx = S_D;
             2'b10:   nx = S_A;
             default: nx = S_E;
           endcase
      S_D: case (in_v)
             2'b00:   nx = S_C;
             2'b01:   nx = S_B;
             2'b10:   nx = S_A;
             default: nx = S_E;
           endcase
      S_E: case (in_v)
             2'b00:   nx = S_F;
             2'b01:   nx = S_F;
             2'b10:   nx = S_A;
             default: nx = S_E;
           endcase
      default: nx = S_A;
    endcase
    return nx;
  endfunction

  // Shortest-path input choice; entries for st==tgt are never used.
  function automatic logic [1:0] policy(input fsm_e st, input logic [2:0] tgt);
    logic [1:0] p;
    p = 2'b00;
    case (tgt)
      3'd0: p = (st == S_F) ? 2'b00 : 2'b10;
      3'd1: case (st)
              S_A, S_D: p = 2'b01;
              S_C, S_E: p = 2'b10;
              default:  p = 2'b00;
            endcase
      3'd2: case (st)
              S_A:     p = 2'b01;
              S_E:     p = 2'b10;
              default: p = 2'b00;
            endcase
      3'd3: case (st)
              S_A, S_C: p = 2'b01;
              S_E:      p = 2'b10;
              default:  p = 2'b00;
            endcase
      3'd4: p = 2'b11;
      3'd5: p = (st == S_E) ? 2'b00 : 2'b11;
      default: p = 2'b00;
    endcase
    return p;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_A;
      r_ctrl   <= C_IDLE;
      r_target <= 3'd0;
      r_steps  <= 3'd0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ctrl   <= w_ctrl_nxt;
      r_target <= w_target_nxt;
      r_steps  <= w_steps_nxt;
      r_err    <= w_err_nxt;
    end
  end

  // The exit to RESP is taken on the edge that lands on the target, so the
  // response follows the last step with no extra settling cycle.
  always_comb begin
    w_ctrl_nxt   = r_ctrl;
    w_state_nxt  = r_state;
    w_target_nxt = r_target;
    w_steps_nxt  = r_steps;
    w_err_nxt    = r_err;
    w_in         = 2'b00;
    w_step       = 1'b0;
    w_req_rdy    = 1'b0;
    w_rsp_val    = 1'b0;
    case (r_ctrl)
      C_IDLE: begin
        w_req_rdy = 1'b1;
        if (req_val) begin
          w_target_nxt = req_target;
          w_steps_nxt  = 3'd0;
          if (req_target > 3'd5) begin
            w_err_nxt  = 1'b1;
            w_ctrl_nxt = C_RESP;
          end else begin
            w_err_nxt  = 1'b0;
            w_ctrl_nxt = (req_target == r_state) ? C_RESP : C_STEP;
          end
        end
      end
      C_STEP: begin
        if (r_state == r_target) begin
          w_ctrl_nxt = C_RESP;
        end else begin
          w_step      = 1'b1;
          w_in        = policy(r_state, r_target);
          w_state_nxt = fsm_next(r_state, w_in);
          w_steps_nxt = r_steps + 3'd1;
          if (w_state_nxt == r_target) w_ctrl_nxt = C_RESP;
        end
      end
      C_RESP: begin
        w_rsp_val = 1'b1;
        if (rsp_rdy) w_ctrl_nxt = C_IDLE;
      end
      default: w_ctrl_nxt = C_IDLE;
    endcase
  end

  assign req_rdy   = w_req_rdy;
  assign rsp_val   = w_rsp_val;
  assign rsp_steps = r_steps;
  assign rsp_err   = r_err;
  assign step      = w_step;
  assign in_       = w_in;
  assign state     = r_state;
  assign out0      = (r_state == S_D);
  assign out1      = (r_state == S_E) || (r_state == S_F);
  assign dbg_ctrl  = r_ctrl;

endmodule

// File: tb/tb_fsm_6s2i2o_steer.sv
// Directed bench for fsm_6s2i2o_steer: hand-computed in_/state walks queued
// ahead of each request and compared cycle by cycle, then the response fields.
module tb_fsm_6s2i2o_steer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_val;
  logic       req_rdy;
  logic [2:0] req_target;
  logic       rsp_val;
  logic       rsp_rdy;
  logic [2:0] rsp_steps;
  logic       rsp_err;
  logic       step;
  logic [1:0] in_;
  logic [2:0] state;
  logic       out0;
  logic       out1;
  logic [1:0] dbg_ctrl;

  int total = 0;
  int bad   = 0;

  logic [1:0] exp_q[$];
  logic [2:0] st_q[$];

  fsm_6s2i2o_steer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_val    (req_val),
    .req_rdy    (req_rdy),
    .req_target (req_target),
    .rsp_val    (rsp_val),
    .rsp_rdy    (rsp_rdy),
    .rsp_steps  (rsp_steps),
    .rsp_err    (rsp_err),
    .step       (step),
    .in_        (in_),
    .state      (state),
    .out0       (out0),
    .out1       (out1),
    .dbg_ctrl   (dbg_ctrl)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Moore decode written from the output table: {out1, out0}
  function automatic logic [1:0] dec(input logic [2:0] s);
    return {(s == 3'd4) || (s == 3'd5), s == 3'd3};
  endfunction

  task automatic push_step(input logic [2:0] st, input logic [1:0] inv);
    st_q.push_back(st);
    exp_q.push_back(inv);
  endtask

  task automatic issue(input logic [2:0] tgt);
    int w;
    w = 0;
    @(negedge clk);
    while (!req_rdy && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("req_rdy_before", req_rdy, 1);
    req_val    = 1'b1;
    req_target = tgt;
    @(posedge clk);
    @(negedge clk);
    req_val    = 1'b0;
  endtask

  task automatic walk(input string tag, input int exp_n, input logic [2:0] exp_steps,
                      input logic exp_err, input logic [2:0] exp_final, input int stall);
    int cyc;
    logic [2:0] st;
    logic [1:0] iv;
    cyc = 0;
    while (!rsp_val && cyc < 10) begin
      chk({tag, "_step"}, step, 1);
      chk({tag, "_rdy_busy"}, req_rdy, 0);
      chk({tag, "_q_avail"}, exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        iv = exp_q.pop_front();
        st = st_q.pop_front();
        chk({tag, "_in"}, in_, iv);
        chk({tag, "_state"}, state, st);
        chk({tag, "_outs"}, {out1, out0}, dec(st));
      end
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_latency"}, cyc, exp_n);
    chk({tag, "_q_left"}, exp_q.size(), 0);
    chk({tag, "_rsp_val"}, rsp_val, 1);
    chk({tag, "_rsp_step0"}, {step, in_}, 0);
    chk({tag, "_steps"}, rsp_steps, exp_steps);
    chk({tag, "_err"}, rsp_err, exp_err);
    chk({tag, "_final"}, state, exp_final);
    chk({tag, "_final_outs"}, {out1, out0}, dec(exp_final));
    for (int i = 0; i < stall; i++) begin
      rsp_rdy = 1'b0;
      if (i == 2) begin
        req_val    = 1'b1;
        req_target = 3'd0;
      end
      @(negedge clk);
      req_val = 1'b0;
      chk({tag, "_stall_val"}, rsp_val, 1);
      chk({tag, "_stall_steps"}, rsp_steps, exp_steps);
      chk({tag, "_stall_err"}, rsp_err, exp_err);
      chk({tag, "_stall_rdy"}, req_rdy, 0);
      chk({tag, "_stall_state"}, state, exp_final);
    end
    rsp_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_rdy = 1'b0;
    chk({tag, "_post_val"}, rsp_val, 0);
    chk({tag, "_post_rdy"}, req_rdy, 1);
    chk({tag, "_post_ctrl"}, dbg_ctrl, 0);
  endtask

  initial begin
    reset_n    = 1'b0;
    req_val    = 1'b0;
    rsp_rdy    = 1'b0;
    req_target = 3'd0;
    #12;
    chk("rst_state", state, 0);
    chk("rst_req_rdy", req_rdy, 1);
    chk("rst_rsp_val", rsp_val, 0);
    chk("rst_step_in", {step, in_}, 0);
    chk("rst_outs", {out1, out0}, 0);
    chk("rst_steps_err", {rsp_steps, rsp_err}, 0);
    chk("rst_ctrl", dbg_ctrl, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // A -> D: 01,00,01
    push_step(3'd0, 2'b01); push_step(3'd1, 2'b00); push_step(3'd2, 2'b01);
    issue(3'd3);
    walk("a2d", 3, 3'd3, 1'b0, 3'd3, 0);

    // D -> F: 11,00 through E
    push_step(3'd3, 2'b11); push_step(3'd4, 2'b00);
    issue(3'd5);
    walk("d2f", 2, 3'd2, 1'b0, 3'd5, 0);

    // F -> D: longest path, 4 steps
    push_step(3'd5, 2'b00); push_step(3'd0, 2'b01);
    push_step(3'd1, 2'b00); push_step(3'd2, 2'b01);
    issue(3'd3);
    walk("f2d", 4, 3'd4, 1'b0, 3'd3, 0);

    // D -> D with a 5-cycle response stall and a stray request pulse
    issue(3'd3);
    walk("d2d", 0, 3'd0, 1'b0, 3'd3, 5);

    // illegal target leaves state alone
    issue(3'd7);
    walk("bad7", 0, 3'd0, 1'b1, 3'd3, 0);
    issue(3'd6);
    walk("bad6", 0, 3'd0, 1'b1, 3'd3, 0);

    push_step(3'd3, 2'b10);
    issue(3'd0);
    walk("d2a", 1, 3'd1, 1'b0, 3'd0, 0);

    push_step(3'd0, 2'b11);
    issue(3'd4);
    walk("a2e", 1, 3'd1, 1'b0, 3'd4, 0);

    push_step(3'd4, 2'b10); push_step(3'd0, 2'b01);
    issue(3'd1);
    walk("e2b", 2, 3'd2, 1'b0, 3'd1, 0);

    push_step(3'd1, 2'b00);
    issue(3'd2);
    walk("b2c", 1, 3'd1, 1'b0, 3'd2, 0);

    push_step(3'd2, 2'b10);
    issue(3'd0);
    walk("c2a", 1, 3'd1, 1'b0, 3'd0, 0);

    // reset mid-walk toward D, after the first step
    issue(3'd3);
    chk("mid_step", step, 1);
    @(posedge clk);
    #1;
    chk("mid_state_b", state, 1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_state", state, 0);
    chk("mid_rst_rdy", req_rdy, 1);
    chk("mid_rst_val", rsp_val, 0);
    chk("mid_rst_step", step, 0);
    chk("mid_rst_ctrl", dbg_ctrl, 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_noval", rsp_val, 0);
    end
    chk("post_rst_state", state, 0);
    chk("post_rst_rdy", req_rdy, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
